// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer: branch/rti/interrupt next-PC arbitration.
// Define FETCH_INT_NEST_EN to re-enable interrupts on handler entry.
module fetch_pc_sequencer #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = 'd32,
  parameter logic [PC_W-1:0] INT_VEC   = 'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch,
  input  logic [15:0]     branch_addr,
  input  logic            stall,
  input  logic            int_req,
  input  logic            rti,
  input  logic [PC_W-1:0] rti_addr,
  input  logic [15:0]     imem_data,
  output logic [PC_W-1:0] pc_out,
  output logic            fetch_valid,
  output logic            flush,
  output logic            int_ack,
  output logic [PC_W-1:0] ret_pc,
  output logic            ret_pc_valid
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    INT_LO = 2'd1,
    INT_HI = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic [PC_W-1:0] r_pc, w_pc_n;
  logic [PC_W-1:0] r_ret, w_ret_n;
  logic [15:0]     r_lo, w_lo_n;
  logic            r_pend, w_pend_n;
  logic            r_en, w_en_n;
  logic            r_flush, w_flush_n;
  logic            r_ack, w_ack_n;
  logic            w_pend;
  logic            w_take;
  logic [PC_W-1:0] w_br;

  assign w_pend = r_pend | int_req;
  assign w_take = w_pend & r_en & ~stall;
  assign w_br   = {{(PC_W-16){branch_addr[15]}}, branch_addr};

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_ret_n   = r_ret;
    w_lo_n    = r_lo;
    w_pend_n  = w_pend;
    w_en_n    = r_en;
    w_flush_n = 1'b0;
    w_ack_n   = 1'b0;
    unique case (r_state)
      INT_LO: begin
        w_lo_n    = imem_data;
        w_pc_n    = INT_VEC + PC_W'(1);
        w_state_n = INT_HI;
      end
      INT_HI: begin
        w_pc_n    = PC_W'({imem_data, r_lo});
        w_state_n = RUN;
`ifdef FETCH_INT_NEST_EN
        w_en_n    = 1'b1;
`else
        w_en_n    = r_en;
`endif
      end
      default: begin
        if (rti) begin
          w_pc_n    = rti_addr;
          w_en_n    = 1'b1;
          w_flush_n = 1'b1;
        end else if (branch) begin
          w_pc_n    = w_br;
          w_flush_n = 1'b1;
        end else if (w_take) begin
          // old pc is squashed here and re-fetched after rti
          w_ret_n   = r_pc;
          w_ack_n   = 1'b1;
          w_en_n    = 1'b0;
          w_pend_n  = 1'b0;
          w_flush_n = 1'b1;
          w_pc_n    = INT_VEC;
          w_state_n = INT_LO;
        end else if (!stall) begin
          w_pc_n = r_pc + PC_W'(1);
        end
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= RESET_VEC;
      r_ret   <= '0;
      r_lo    <= '0;
      r_pend  <= 1'b0;
      r_en    <= 1'b1;
      r_flush <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_ret   <= w_ret_n;
      r_lo    <= w_lo_n;
      r_pend  <= w_pend_n;
      r_en    <= w_en_n;
      r_flush <= w_flush_n;
      r_ack   <= w_ack_n;
    end
  end

  // valid as soon as reset is released, so RESET_VEC itself is fetched
  assign fetch_valid  = reset & (r_state == RUN);
  assign pc_out       = r_pc;
  assign flush        = r_flush;
  assign int_ack      = r_ack;
  assign ret_pc       = r_ret;
  assign ret_pc_valid = r_ack;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer with a cycle-level model.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, branch, stall, int_req, rti;
  logic [15:0] branch_addr, imem_data;
  logic [31:0] rti_addr, pc_out, ret_pc;
  logic        fetch_valid, flush, int_ack, ret_pc_valid;
  logic [15:0] w0, w1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc, m_ret;
  logic [15:0] m_lo;
  int          m_bub;
  logic        m_pend, m_en, m_flush, m_ack;

  always #5 clk = ~clk;

  always_comb
    imem_data = (pc_out == 32'd0) ? w0 :
                (pc_out == 32'd1) ? w1 :
                (pc_out[15:0] ^ 16'hA5C3);

  fetch_pc_sequencer dut (
    .clk(clk), .reset(reset), .branch(branch),
    .branch_addr(branch_addr), .stall(stall),
    .int_req(int_req), .rti(rti), .rti_addr(rti_addr),
    .imem_data(imem_data), .pc_out(pc_out),
    .fetch_valid(fetch_valid), .flush(flush),
    .int_ack(int_ack), .ret_pc(ret_pc),
    .ret_pc_valid(ret_pc_valid)
  );

  function automatic logic [15:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return w0;
    if (a == 32'd1) return w1;
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] a,
                     input logic [31:0] e);
    vectors++;
    assert (a === e) else begin
      miscompares++;
      $error("FAIL %s got %h expected %h", tag, a, e);
    end
  endtask

  // m_bub counts remaining vector-read bubbles: 2 = low word, 1 = high word
  task automatic model_edge();
    logic p;
    if (!reset) begin
      m_pc = 32'd32; m_bub = 0; m_pend = 0; m_en = 1;
      m_lo = 0; m_ret = 0; m_flush = 0; m_ack = 0;
      return;
    end
    p = m_pend | int_req;
    m_pend = p;
    m_flush = 0;
    m_ack = 0;
    if (m_bub == 2) begin
      m_lo = word_at(m_pc); m_pc = 32'd1; m_bub = 1;
    end else if (m_bub == 1) begin
      m_pc = {word_at(m_pc), m_lo}; m_bub = 0;
`ifdef FETCH_INT_NEST_EN
      m_en = 1;
`endif
    end else if (rti) begin
      m_pc = rti_addr; m_en = 1; m_flush = 1;
    end else if (branch) begin
      m_pc = {{16{branch_addr[15]}}, branch_addr}; m_flush = 1;
    end else if (p && m_en && !stall) begin
      m_ret = m_pc; m_ack = 1; m_en = 0; m_pend = 0;
      m_flush = 1; m_pc = 32'd0; m_bub = 2;
    end else if (!stall) begin
      m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("pc", pc_out, m_pc);
    chk("fv", {31'd0, fetch_valid}, {31'd0, reset && m_bub == 0});
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
    chk("ack", {31'd0, int_ack}, {31'd0, m_ack});
    chk("rpv", {31'd0, ret_pc_valid}, {31'd0, m_ack});
    chk("retpc", ret_pc, m_ret);
  endtask

  task automatic cyc();
    model_edge();
    @(negedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    branch = 0; stall = 0; int_req = 0; rti = 0;
  endtask

  initial begin
    reset = 0; idle();
    branch_addr = 0; rti_addr = 0;
    w0 = 16'h0100; w1 = 16'h0000;
    repeat (3) cyc();
    chk("rst_pc", pc_out, 32'd32);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);

    reset = 1; #1;
    chk("rel_fv", {31'd0, fetch_valid}, 32'd1);
    chk("rel_pc", pc_out, 32'd32);
    cyc(); chk("seq33", pc_out, 32'd33);
    cyc(); chk("seq34", pc_out, 32'd34);

    for (int i = 0; i < 20 && pc_out != 32'd40; i++) cyc();
    chk("reach40", pc_out, 32'd40);
    branch = 1; stall = 1; branch_addr = 16'hFFF0;
    cyc();
    chk("br_pc", pc_out, 32'hFFFFFFF0);
    chk("br_fl", {31'd0, flush}, 32'd1);
    idle(); cyc();
    chk("br_fl0", {31'd0, flush}, 32'd0);

    branch = 1; branch_addr = 16'd50; cyc(); idle();
    chk("at50", pc_out, 32'd50);
    int_req = 1; cyc(); int_req = 0;
    chk("e_ack", {31'd0, int_ack}, 32'd1);
    chk("e_ret", ret_pc, 32'd50);
    chk("e_pc0", pc_out, 32'd0);
    cyc(); chk("e_pc1", pc_out, 32'd1);
    chk("e_fv", {31'd0, fetch_valid}, 32'd0);
    cyc(); chk("e_hnd", pc_out, 32'd256);

    rti = 1; rti_addr = 32'd50; cyc(); idle();
    chk("rti50", pc_out, 32'd50);
    stall = 1; int_req = 1; cyc(); int_req = 0;
    repeat (3) cyc();
    chk("stl_pc", pc_out, 32'd50);
    chk("stl_ack", {31'd0, int_ack}, 32'd0);
    stall = 0; cyc();
    chk("stl_ent", {31'd0, int_ack}, 32'd1);
    chk("stl_ret", ret_pc, 32'd50);

    int_req = 1; cyc(); int_req = 0;
    cyc(); chk("h2_pc", pc_out, 32'd256);
`ifdef FETCH_INT_NEST_EN
    cyc();
    chk("nest_ack", {31'd0, int_ack}, 32'd1);
    chk("nest_ret", ret_pc, 32'd256);
`else
    cyc(); cyc();
    chk("defer", {31'd0, int_ack}, 32'd0);
    rti = 1; rti_addr = 32'd50; cyc(); rti = 0;
    chk("ret50", pc_out, 32'd50);
    cyc();
    chk("n2_ack", {31'd0, int_ack}, 32'd1);
    chk("n2_ret", ret_pc, 32'd50);
`endif
    cyc(); cyc();
    rti = 1; rti_addr = 32'd60; cyc(); rti = 0;
    int_req = 1; cyc(); int_req = 0;
    cyc(); chk("hi_pc", pc_out, 32'd1);
    reset = 0; cyc();
    chk("ar_pc", pc_out, 32'd32);
    reset = 1;
    repeat (3) begin
      cyc();
      chk("ar_ack", {31'd0, int_ack}, 32'd0);
    end

    w0 = 16'($urandom); w1 = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      branch = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      int_req = ($urandom_range(0, 11) == 0);
      rti = ($urandom_range(0, 14) == 0);
      branch_addr = 16'($urandom);
      rti_addr = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Owns and sequences the fetch-stage program counter and drives the instruction-memory address.
- Arbitrates the next-PC sources: reset vector, branch target, interrupt vector fetch, return-from-interrupt and sequential PC+1. Applies stall.
- Runs a multi-cycle interrupt entry: squashes the current fetch, reads a 32-bit handler address from two 16-bit code-memory words, then jumps to it.
- Sits between the decode/execute control signals and the instruction memory; its output feeds the IF/ID register.

Parameters:
- PC_W, 32, program counter width.
- RESET_VEC, 32, PC value loaded by reset.
- INT_VEC, 0, code-memory address of the handler-address low word. The high word is at INT_VEC+1.

Ports:
- clk  in  1  clock; all state updates on the negative edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the clock's active edge.
- branch  in  1  take branch this cycle.
- branch_addr  in  16  branch target, sign-extended to PC_W.
- stall  in  1  hold PC (hazard stall).
- int_req  in  1  interrupt request pulse/level; latched into pending.
- rti  in  1  return-from-interrupt this cycle.
- rti_addr  in  PC_W  return address (popped by the execute stage).
- imem_data  in  16  code-memory word at pc_out (combinational read).
- pc_out  out  PC_W  code-memory address / current PC.
- fetch_valid  out  1  imem_data is a real instruction for IF/ID.
- flush  out  1  squash the IF/ID contents this cycle.
- int_ack  out  1  one-cycle pulse on interrupt entry.
- ret_pc  out  PC_W  address to push on interrupt entry.
- ret_pc_valid  out  1  one-cycle pulse qualifying ret_pc.

Behaviour:
- States: RUN, INT_LO, INT_HI.
- Reset (reset==0 at the clock edge):
  - pc_out=RESET_VEC, state=RUN.
  - int_pending=0, int_en=1, lo_reg=0, ret_pc=0.
  - fetch_valid=0, flush=0, int_ack=0, ret_pc_valid=0.
  - Reset mid-entry aborts the entry and drops any pending interrupt.
  - First cycle after reset release: fetch_valid=1.
- int_pending: set by int_req==1 in any non-reset cycle. Cleared only on entry.
- RUN, priority per edge, highest first:
  1. rti: pc=rti_addr, int_en=1, flush=1. rti and branch together: rti wins.
  2. branch: pc=sign-extended branch_addr, flush=1. Branch beats stall; a branch is never lost. int_pending stays set.
  3. int_pending && int_en && !stall: ret_pc=pc_out, ret_pc_valid=1, int_ack=1, int_en=0, int_pending=0, flush=1, pc=INT_VEC, go INT_LO. The instruction at the old pc_out is squashed and re-fetched after return.
  4. stall: pc holds, fetch_valid stays 1, no flush. Interrupt is deferred.
  5. else: pc=pc+1, wrapping modulo 2^PC_W.
- INT_LO:
  - fetch_valid=0.
  - lo_reg=imem_data, pc=INT_VEC+1, go INT_HI.
  - stall, branch and rti are ignored.
- INT_HI:
  - fetch_valid=0.
  - pc={imem_data, lo_reg} (PC_W=32), go RUN.
  - stall, branch and rti are ignored.
- Interrupt latency: two bubble cycles, then the first handler instruction is presented on the third cycle after int_ack.
- An int_req arriving during INT_LO/INT_HI sets int_pending. It is taken only after int_en is set again.
- int_ack, ret_pc_valid and flush are registered, single-cycle, and never asserted on consecutive cycles from the same event.

Optional Feature:
- Macro: FETCH_INT_NEST_EN.
- Defined: int_en is set again on the INT_HI→RUN transition, so a pending interrupt can preempt the handler from its first instruction. Each nested entry produces its own ret_pc_valid push.
- Undefined: int_en stays 0 from entry until rti. Requests stay pending.

Test Plan:
- Reset held low 3 cycles, then released, with no other inputs: pc_out=32 and fetch_valid=0 during reset. After release pc_out steps 32,33,34 each cycle.
- Run to pc_out=40, then branch=1 with branch_addr=16'hFFF0 in the same cycle as stall=1: next pc_out=32'hFFFFFFF0, flush=1 for one cycle.
- At pc_out=50, int_req pulse with memory word0=16'h0100 and word1=16'h0000: int_ack=1, ret_pc_valid=1, ret_pc=50. pc_out then reads 0 and 1 with fetch_valid=0, then 256.
- int_req while stall=1 for 4 cycles: no entry during the stall. Entry occurs in the first cycle stall=0, with ret_pc equal to the stalled pc.
- Second int_req inside the handler, then rti with rti_addr=50:
  - Without FETCH_INT_NEST_EN: pc_out=50, then the second entry fires, with ret_pc=50.
  - With FETCH_INT_NEST_EN: the second entry fires immediately after the first entry completes.
- reset=0 asserted during INT_HI: pc_out=32 on the next edge, state RUN, no int_ack after release.
